// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO pop streamer.
package fifo_stream_pkg;

    localparam int unsigned FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order output buffer; head entry drives the output port.
module stream_skid_buf2 #(
    parameter int unsigned DATA_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              pop;

    assign out_valid = occ_q != 2'd0;
    assign out_data  = head_q;
    assign occupancy = occ_q;
    assign pop       = out_valid & out_ready;

    // The caller never pushes into a full buffer, so occupancy stays within 0..2.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = in_data;
                end else begin
                    tail_d = in_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                // Head goes to zero once the buffer empties so m_data is clean when idle.
                head_d = (occ_q == 2'd2) ? tail_q : '0;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = in_data;
                end else begin
                    head_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_pop_streamer.sv
// Pops a FIFO into a framed valid/ready stream with early-close (flush) and a frame counter.
module fifo_pop_streamer
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_W    = 3,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_W-1:0]      fifo_data,
    output logic                   fifo_pop,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_last,
    input  logic                   flush,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_e                 state_q, state_d;
    logic [1:0]             occupancy;
    logic [7:0]             idx_q, idx_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   xfer;

    // Pop depends only on registered state and FIFO/enable inputs; m_ready never reaches it.
    assign fifo_pop  = (state_q == RUN) & enable & ~fifo_empty & (occupancy < 2'd2);
    assign xfer      = m_valid & m_ready;
    assign m_last    = m_valid & ((idx_q == LAST_IDX) | flush_pend_q);
    assign busy      = state_q != IDLE;
    assign frame_cnt = frame_cnt_q;

    stream_skid_buf2 #(
        .DATA_W(DATA_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_pop),
        .in_data  (fifo_data),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data),
        .occupancy(occupancy)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = (occupancy != 2'd0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (occupancy == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush arriving on the edge that closes a frame is absorbed by that close.
    always_comb begin
        idx_d        = idx_q;
        flush_pend_d = flush_pend_q | flush;
        frame_cnt_d  = frame_cnt_q;
        if (xfer) begin
            if (m_last) begin
                idx_d        = '0;
                flush_pend_d = 1'b0;
                frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
            end else begin
                idx_d = idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Randomised bench for fifo_pop_streamer against a queue-based FIFO and frame model.
module tb_fifo_pop_streamer;

    localparam int DW = 3;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_pop, m_valid, m_last, busy;
    logic [DW-1:0] m_data;
    logic [7:0]    frame_cnt;

    always #5 clk = ~clk;

    fifo_pop_streamer #(
        .DATA_W   (DW),
        .FRAME_LEN(FL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .flush     (flush),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] want[$];
    logic [DW-1:0] rx_d[$];
    bit            rx_l[$];
    bit            rx_fmid[$];
    bit            rx_fedge[$];
    bit            exp_l[$];
    int            rx_cyc[$];
    int            cyc, pops, hold_viol, underflow, exp_closes;
    bit            fmid, fedge, prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    function automatic void refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
    endfunction

    function automatic void clear_log();
        rx_d.delete(); rx_l.delete(); rx_fmid.delete(); rx_fedge.delete(); rx_cyc.delete();
        want.delete();
        fmid = 0; fedge = 0; prev_stall = 0;
        cyc = 0; pops = 0; hold_viol = 0; underflow = 0;
    endfunction

    function automatic void push_words(int n, bit counting);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = counting ? DW'(i + 1) : DW'($urandom_range(7, 0));
            fq.push_back(w);
            want.push_back(w);
        end
        refresh();
    endfunction

    // Frame model: a frame closes on its FL-th beat, or on the first beat after a flush
    // edge, except that a flush landing on the very edge of a closing beat is absorbed.
    function automatic void build_expected();
        int pos = 0;
        bit prevlast = 0;
        bit pend, last;
        exp_l.delete();
        exp_closes = 0;
        foreach (rx_d[i]) begin
            pend = rx_fmid[i] || (rx_fedge[i] && !prevlast);
            last = (pos == FL - 1) || pend;
            exp_l.push_back(last);
            if (last) exp_closes++;
            pos      = last ? 0 : pos + 1;
            prevlast = last;
        end
    endfunction

    function automatic int stream_errs();
        int e = 0;
        build_expected();
        if (rx_d.size() != want.size()) e++;
        foreach (rx_d[i]) begin
            if (i >= want.size() || rx_d[i] !== want[i]) e++;
            if (rx_l[i] !== exp_l[i]) e++;
        end
        return e;
    endfunction

    // One clock: sample just before the edge, log transfers and flush timing, then
    // retire the popped word from the FIFO model after the edge.
    task automatic tick();
        logic pop_s, fl_s;
        bit   xfer;
        #2;
        pop_s = fifo_pop;
        fl_s  = flush;
        xfer  = m_valid && m_ready;
        if (prev_stall && m_valid && (m_data !== prev_d || m_last !== prev_l)) hold_viol++;
        prev_stall = m_valid && !m_ready;
        prev_d     = m_data;
        prev_l     = m_last;
        if (pop_s && fq.size() == 0) underflow++;
        if (xfer) begin
            rx_d.push_back(m_data);
            rx_l.push_back(m_last);
            rx_fmid.push_back(fmid);
            rx_fedge.push_back(fedge);
            rx_cyc.push_back(cyc);
            fmid  = 0;
            fedge = fl_s;
        end else if (fl_s) begin
            fmid = 1;
        end
        if (pop_s) pops++;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_s && fq.size() > 0) void'(fq.pop_front());
        refresh();
    endtask

    task automatic run_until(int n, int budget);
        int g = 0;
        while (rx_d.size() < n && g < budget) begin
            tick();
            g++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; m_ready = 1'b0; flush = 1'b0;
        fq.delete();
        refresh();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; m_ready = 1'b1;
        fq.delete();
        fq.push_back(3'd5);
        refresh();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({fifo_pop, m_valid, m_last, busy} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: pop/valid/last/busy got %b want 0000",
                     {fifo_pop, m_valid, m_last, busy});
        end
        n_cmp++;
        if (m_data !== '0) begin
            n_err++; $display("FAIL reset_m_data: got %0d want 0", m_data);
        end
        n_cmp++;
        if (frame_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_stream();
        int e, bad;
        do_reset();
        push_words(7, 1'b1);
        enable = 1'b1; m_ready = 1'b1;
        run_until(7, 40);
        e = stream_errs();
        n_cmp++;
        if (e !== 0) begin
            n_err++; $display("FAIL stream_data_last: got %0d errors (%0d beats) want 0",
                              e, rx_d.size());
        end
        bad = 0;
        foreach (rx_cyc[i]) if (rx_cyc[i] != rx_cyc[0] + i) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL stream_back_to_back: got %0d gaps want 0", bad);
        end
        n_cmp++;
        if (frame_cnt !== 8'd1) begin
            n_err++; $display("FAIL stream_frame_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int e;
        do_reset();
        push_words(5, 1'b0);
        enable = 1'b1; m_ready = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (pops !== 2) begin
            n_err++; $display("FAIL bp_pop_count: got %0d want 2", pops);
        end
        n_cmp++;
        if (fq.size() !== 3) begin
            n_err++; $display("FAIL bp_fifo_left: got %0d want 3", fq.size());
        end
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== want[0]) begin
            n_err++; $display("FAIL bp_head: got valid=%b data=%0d want valid=1 data=%0d",
                              m_valid, m_data, want[0]);
        end
        m_ready = 1'b1;
        run_until(5, 30);
        e = stream_errs();
        n_cmp++;
        if (e !== 0) begin
            n_err++; $display("FAIL bp_stream: got %0d errors want 0", e);
        end
        n_cmp++;
        if (hold_viol !== 0) begin
            n_err++; $display("FAIL bp_hold_stable: got %0d changes want 0", hold_viol);
        end
    endtask

    task automatic test_flush();
        int e;
        do_reset();
        push_words(7, 1'b0);
        enable = 1'b1; m_ready = 1'b1;
        run_until(2, 30);
        m_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; m_ready = 1'b1;
        run_until(7, 30);
        n_cmp++;
        if (rx_l.size() < 7 || rx_l[2] !== 1'b1 || rx_l[6] !== 1'b1) begin
            n_err++; $display("FAIL flush_early_close: got %0d beats, last flags wrong, want beats 3 and 7 last",
                              rx_l.size());
        end
        n_cmp++;
        if (frame_cnt !== 8'd2) begin
            n_err++; $display("FAIL flush_frame_cnt: got %0d want 2", frame_cnt);
        end
        // Flush held pending across a naturally final beat must close just one frame.
        push_words(8, 1'b0);
        run_until(10, 30);
        m_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; m_ready = 1'b1;
        run_until(15, 40);
        e = stream_errs();
        n_cmp++;
        if (e !== 0) begin
            n_err++; $display("FAIL flush_stream: got %0d errors want 0", e);
        end
        n_cmp++;
        if (frame_cnt !== 8'd4) begin
            n_err++; $display("FAIL flush_coincide_cnt: got %0d want 4", frame_cnt);
        end
    endtask

    task automatic test_drain();
        int e;
        logic [DW-1:0] w0, w1;
        do_reset();
        push_words(4, 1'b0);
        w0 = want[0]; w1 = want[1];
        want.delete();
        want.push_back(w0);
        want.push_back(w1);
        enable = 1'b1; m_ready = 1'b0;
        repeat (5) tick();
        enable = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || fifo_pop !== 1'b0 || m_valid !== 1'b1) begin
            n_err++; $display("FAIL drain_state: got busy=%b pop=%b valid=%b want 1 0 1",
                              busy, fifo_pop, m_valid);
        end
        m_ready = 1'b1;
        run_until(2, 10);
        repeat (3) tick();
        e = stream_errs();
        n_cmp++;
        if (e !== 0) begin
            n_err++; $display("FAIL drain_stream: got %0d errors want 0", e);
        end
        n_cmp++;
        if (busy !== 1'b0 || fq.size() !== 2 || pops !== 2) begin
            n_err++; $display("FAIL drain_idle: got busy=%b fifo_left=%0d pops=%0d want 0 2 2",
                              busy, fq.size(), pops);
        end
    endtask

    task automatic test_random();
        int e, g;
        do_reset();
        push_words(40, 1'b0);
        g = 0;
        while (rx_d.size() < 40 && g < 3000) begin
            enable  = ($urandom_range(9, 0) != 0);
            m_ready = ($urandom_range(9, 0) < 7);
            flush   = ($urandom_range(7, 0) == 0);
            tick();
            g++;
        end
        flush = 1'b0;
        e = stream_errs();
        n_cmp++;
        if (e !== 0) begin
            n_err++; $display("FAIL rand_stream: got %0d errors (%0d beats) want 0", e, rx_d.size());
        end
        n_cmp++;
        if (hold_viol !== 0 || underflow !== 0) begin
            n_err++; $display("FAIL rand_protocol: got hold=%0d underflow=%0d want 0 0",
                              hold_viol, underflow);
        end
        n_cmp++;
        if (frame_cnt !== 8'(exp_closes % 256)) begin
            n_err++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, exp_closes % 256);
        end
    endtask

    task automatic test_wrap();
        int e, g;
        bit seen;
        do_reset();
        push_words(256 * FL, 1'b0);
        enable = 1'b1;
        g = 0;
        seen = 0;
        while (rx_d.size() < 256 * FL && g < 5000) begin
            m_ready = ($urandom_range(3, 0) != 0);
            tick();
            g++;
            if (rx_d.size() == 255 * FL && !seen) begin
                seen = 1;
                n_cmp++;
                if (frame_cnt !== 8'd255) begin
                    n_err++; $display("FAIL wrap_255: got %0d want 255", frame_cnt);
                end
            end
        end
        e = stream_errs();
        n_cmp++;
        if (e !== 0) begin
            n_err++; $display("FAIL wrap_stream: got %0d errors (%0d beats) want 0", e, rx_d.size());
        end
        n_cmp++;
        if (frame_cnt !== 8'd0) begin
            n_err++; $display("FAIL wrap_frame_cnt: got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        do_reset();
        push_words(10, 1'b0);
        enable = 1'b1; m_ready = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (m_valid !== 1'b1 || pops !== 2) begin
            n_err++; $display("FAIL rmid_setup: got valid=%b pops=%0d want 1 2", m_valid, pops);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({fifo_pop, m_valid, m_last, busy} !== 4'b0 || m_data !== '0 || frame_cnt !== 8'd0) begin
            n_err++; $display("FAIL rmid_async_clear: got ctrl=%b data=%0d cnt=%0d want 0 0 0",
                              {fifo_pop, m_valid, m_last, busy}, m_data, frame_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_log();
        foreach (fq[i]) want.push_back(fq[i]);
        m_ready = 1'b1;
        run_until(8, 40);
        e = stream_errs();
        n_cmp++;
        if (e !== 0 || rx_l.size() < 4 || rx_l[3] !== 1'b1) begin
            n_err++; $display("FAIL rmid_restart: got %0d errors (%0d beats) want 0, 4th beat last",
                              e, rx_l.size());
        end
        n_cmp++;
        if (frame_cnt !== 8'd2) begin
            n_err++; $display("FAIL rmid_frame_cnt: got %0d want 2", frame_cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_drain();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_pop_streamer.md
FIFO_POP_STREAMER -- requirements
Module: fifo_pop_streamer

Interface
REQ-001 Parameter DATA_W, default 3: FIFO word width and m_data width.
REQ-002 Parameter FRAME_LEN, default 4, legal 2..256: beats per frame.
REQ-003 Clock clk: single clock, same clock as the FIFO read side.
REQ-004 Reset reset: asynchronous, active-low.
REQ-005 Port list (name, direction, width, meaning) SHALL be:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- enable  in  1  permits popping the FIFO
- fifo_empty  in  1  FIFO read-side empty flag
- fifo_data  in  DATA_W  FIFO head word; valid whenever fifo_empty=0
- fifo_pop  out  1  pop request to the FIFO
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  output beat data
- m_last  out  1  final beat of the frame
- flush  in  1  single-cycle request to close the current frame early
- frame_cnt  out  8  count of completed frames
- busy  out  1  asserted in any state other than IDLE

Function
REQ-006 fifo_pop SHALL equal enable & !fifo_empty & (buffer occupancy < 2), derived only from registers and these inputs, with no path from m_ready.
REQ-007 On each clk edge where fifo_pop=1, fifo_data SHALL be written into a 2-entry in-order output buffer.
REQ-008 Pop-to-m_valid latency SHALL be 1 cycle when the buffer is empty.
REQ-009 Sustained throughput SHALL be 1 beat per cycle while the FIFO is non-empty and m_ready=1.
REQ-010 m_valid SHALL be 1 exactly when buffer occupancy > 0; m_data SHALL be the oldest entry.
REQ-011 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-012 A beat transfers when m_valid & m_ready; simultaneous pop and transfer SHALL leave occupancy unchanged.
REQ-013 A beat index counter (0..FRAME_LEN-1) SHALL advance on each transfer and wrap to 0.
REQ-014 m_last SHALL be 1 when the index equals FRAME_LEN-1 or a flush is pending.
REQ-015 flush SHALL set a pending flag. The next transferred beat carries m_last=1, then the flag and index clear.
REQ-016 flush asserted while the buffer is empty SHALL hold pending until the next beat.
REQ-017 flush coinciding with a natural last beat SHALL close only one frame.
REQ-018 frame_cnt SHALL increment by 1 on each transfer with m_last=1 and wrap 255->0.
REQ-019 The FSM SHALL have three states: IDLE, RUN, DRAIN.
REQ-020 FSM transitions SHALL be:
- IDLE->RUN on enable=1
- RUN->DRAIN on enable=0 with occupancy > 0
- RUN->IDLE on enable=0 with occupancy = 0
- DRAIN->IDLE when occupancy reaches 0
- DRAIN->RUN on enable=1
REQ-021 fifo_pop SHALL be 0 in IDLE and DRAIN.
REQ-022 In DRAIN, buffered beats SHALL still be delivered.
REQ-023 When fifo_empty=1, fifo_pop SHALL be 0 regardless of state; no underflow pop is permitted.

Reset
REQ-024 On reset=0, the block SHALL set:
- state IDLE
- occupancy 0 and all buffered data discarded
- index 0 and flush pending 0
- frame_cnt 0
- fifo_pop 0, m_valid 0, m_last 0, busy 0
- m_data 0
REQ-025 Reset asserted mid-frame SHALL abort the frame with no m_last emitted; the first beat after reset SHALL have index 0.
REQ-026 Reset deassertion SHALL take effect at the first clk edge with reset=1.

Structure
REQ-027 Shared package fifo_stream_pkg SHALL hold the state enumeration (IDLE, RUN, DRAIN) and the constant FRAME_CNT_W=8.
REQ-028 The 2-entry buffer SHALL be the sub-module stream_skid_buf2: DATA_W parameter, push/data in, valid/ready/data out, occupancy out.

Verification
REQ-029 A bench SHALL cover these scenarios (DATA_W=3, FRAME_LEN=4):
- Scenario 1: FIFO holds 1..7, enable=1, m_ready=1 -> m_data 1..7 on consecutive cycles; m_last on 4; frame_cnt=1.
- Scenario 2: FIFO holds 5 words, m_ready=0 -> fifo_pop exactly 2 cycles; m_data holds the first word stable. Then m_ready=1 -> remaining 3 words popped in order, no loss or duplication.
- Scenario 3: flush after beat 2 of a frame -> beat 3 has m_last=1; the next frame restarts at index 0; frame_cnt increments.
- Scenario 4: enable drops with 2 words buffered -> state DRAIN, fifo_pop=0, both beats delivered, then IDLE with busy=0.
- Scenario 5: 256 full frames -> frame_cnt wraps to 0.
- Scenario 6: reset=0 mid-frame with 2 words buffered -> all outputs 0 immediately; after release, the next frame's m_last falls on the 4th beat.
